// File: rtl/rob_retire.sv
// Reorder buffer with dual-way in-order allocation, three completion ports and
// dual-way in-order retirement that returns old physical registers to the free pool.
module rob_retire #(
  parameter int ROB_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_valid_1,
  input  logic        alloc_valid_2,
  input  logic [5:0]  alloc_pd_1,
  input  logic [5:0]  alloc_pd_2,
  input  logic [5:0]  alloc_old_pd_1,
  input  logic [5:0]  alloc_old_pd_2,
  input  logic        alloc_store_1,
  input  logic        alloc_store_2,
  output logic        alloc_ready,
  output logic [3:0]  alloc_idx_1,
  output logic [3:0]  alloc_idx_2,
  input  logic        cmp_valid_1,
  input  logic        cmp_valid_2,
  input  logic        cmp_valid_3,
  input  logic [3:0]  cmp_rob_1,
  input  logic [3:0]  cmp_rob_2,
  input  logic [3:0]  cmp_rob_3,
  input  logic [31:0] cmp_result_1,
  input  logic [31:0] cmp_result_2,
  input  logic [31:0] cmp_result_3,
  output logic        retire_valid_1,
  output logic        retire_valid_2,
  output logic        retire_flag_1,
  output logic        retire_flag_2,
  output logic [5:0]  fp_ind_1,
  output logic [5:0]  fp_ind_2,
  output logic [5:0]  retire_pd_1,
  output logic [5:0]  retire_pd_2,
  output logic [31:0] retire_data_1,
  output logic [31:0] retire_data_2,
  output logic        retire_store_1,
  output logic        retire_store_2,
  output logic [4:0]  rob_count
);

  localparam int IW = $clog2(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] v_q, v_d, comp_q, comp_d, store_q, store_d;
  logic [5:0]           pd_q [ROB_DEPTH];
  logic [5:0]           pd_d [ROB_DEPTH];
  logic [5:0]           old_pd_q [ROB_DEPTH];
  logic [5:0]           old_pd_d [ROB_DEPTH];
  logic [31:0]          result_q [ROB_DEPTH];
  logic [31:0]          result_d [ROB_DEPTH];
  logic [IW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [4:0]           count_q, count_d;

  logic        retire_valid_1_q, retire_valid_1_d, retire_valid_2_q, retire_valid_2_d;
  logic        retire_flag_1_q, retire_flag_1_d, retire_flag_2_q, retire_flag_2_d;
  logic [5:0]  fp_ind_1_q, fp_ind_1_d, fp_ind_2_q, fp_ind_2_d;
  logic [5:0]  retire_pd_1_q, retire_pd_1_d, retire_pd_2_q, retire_pd_2_d;
  logic [31:0] retire_data_1_q, retire_data_1_d, retire_data_2_q, retire_data_2_d;
  logic        retire_store_1_q, retire_store_1_d, retire_store_2_q, retire_store_2_d;

  logic          acc_1_s, acc_2_s, ret_1_s, ret_2_s;
  logic [IW-1:0] head_p1_s, idx_2_s;
  logic [1:0]    n_alloc_s, n_ret_s;

  assign alloc_ready = (count_q <= 5'd14);
  assign alloc_idx_1 = tail_q;
  assign alloc_idx_2 = idx_2_s;

  // Next-state computation: retire selection, per-row update priority, pointers and count
  always_comb begin
    v_d      = v_q;
    comp_d   = comp_q;
    store_d  = store_q;
    pd_d     = pd_q;
    old_pd_d = old_pd_q;
    result_d = result_q;

    idx_2_s   = alloc_valid_1 ? (tail_q + 4'd1) : tail_q;
    acc_1_s   = alloc_ready & alloc_valid_1;
    acc_2_s   = alloc_ready & alloc_valid_2;
    n_alloc_s = {1'b0, acc_1_s} + {1'b0, acc_2_s};

    head_p1_s = head_q + 4'd1;
    ret_1_s   = v_q[head_q] & comp_q[head_q];
    ret_2_s   = ret_1_s & v_q[head_p1_s] & comp_q[head_p1_s];
    n_ret_s   = {1'b0, ret_1_s} + {1'b0, ret_2_s};

    // Allocation overrides everything; retiring rows are never free rows, so order between them is moot
    for (int r = 0; r < ROB_DEPTH; r++) begin
      if (acc_1_s && (tail_q == IW'(r))) begin
        v_d[r] = 1'b1; comp_d[r] = 1'b0; store_d[r] = alloc_store_1;
        pd_d[r] = alloc_pd_1; old_pd_d[r] = alloc_old_pd_1; result_d[r] = 32'd0;
      end else if (acc_2_s && (idx_2_s == IW'(r))) begin
        v_d[r] = 1'b1; comp_d[r] = 1'b0; store_d[r] = alloc_store_2;
        pd_d[r] = alloc_pd_2; old_pd_d[r] = alloc_old_pd_2; result_d[r] = 32'd0;
      end else if ((ret_1_s && (head_q == IW'(r))) || (ret_2_s && (head_p1_s == IW'(r)))) begin
        v_d[r] = 1'b0; comp_d[r] = 1'b0;
      end else if (v_q[r] && cmp_valid_1 && (cmp_rob_1 == IW'(r))) begin
        comp_d[r] = 1'b1; result_d[r] = cmp_result_1;
      end else if (v_q[r] && cmp_valid_2 && (cmp_rob_2 == IW'(r))) begin
        comp_d[r] = 1'b1; result_d[r] = cmp_result_2;
      end else if (v_q[r] && cmp_valid_3 && (cmp_rob_3 == IW'(r))) begin
        comp_d[r] = 1'b1; result_d[r] = cmp_result_3;
      end else begin
        comp_d[r] = comp_q[r];
      end
    end

    tail_d  = tail_q + {2'b00, n_alloc_s};
    head_d  = head_q + {2'b00, n_ret_s};
    count_d = count_q + {3'b000, n_alloc_s} - {3'b000, n_ret_s};

    retire_valid_1_d = ret_1_s;
    retire_valid_2_d = ret_2_s;
    retire_flag_1_d  = ret_1_s & ~store_q[head_q];
    retire_flag_2_d  = ret_2_s & ~store_q[head_p1_s];
    fp_ind_1_d       = retire_flag_1_d ? old_pd_q[head_q]    : 6'd0;
    fp_ind_2_d       = retire_flag_2_d ? old_pd_q[head_p1_s] : 6'd0;
    retire_pd_1_d    = ret_1_s ? pd_q[head_q]        : 6'd0;
    retire_pd_2_d    = ret_2_s ? pd_q[head_p1_s]     : 6'd0;
    retire_data_1_d  = ret_1_s ? result_q[head_q]    : 32'd0;
    retire_data_2_d  = ret_2_s ? result_q[head_p1_s] : 32'd0;
    retire_store_1_d = ret_1_s & store_q[head_q];
    retire_store_2_d = ret_2_s & store_q[head_p1_s];
  end

  // State and registered retire outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      comp_q  <= '0;
      store_q <= '0;
      for (int r = 0; r < ROB_DEPTH; r++) begin
        pd_q[r]     <= 6'd0;
        old_pd_q[r] <= 6'd0;
        result_q[r] <= 32'd0;
      end
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= 5'd0;
      retire_valid_1_q <= 1'b0;
      retire_valid_2_q <= 1'b0;
      retire_flag_1_q  <= 1'b0;
      retire_flag_2_q  <= 1'b0;
      fp_ind_1_q       <= 6'd0;
      fp_ind_2_q       <= 6'd0;
      retire_pd_1_q    <= 6'd0;
      retire_pd_2_q    <= 6'd0;
      retire_data_1_q  <= 32'd0;
      retire_data_2_q  <= 32'd0;
      retire_store_1_q <= 1'b0;
      retire_store_2_q <= 1'b0;
    end else begin
      v_q              <= v_d;
      comp_q           <= comp_d;
      store_q          <= store_d;
      pd_q             <= pd_d;
      old_pd_q         <= old_pd_d;
      result_q         <= result_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      retire_valid_1_q <= retire_valid_1_d;
      retire_valid_2_q <= retire_valid_2_d;
      retire_flag_1_q  <= retire_flag_1_d;
      retire_flag_2_q  <= retire_flag_2_d;
      fp_ind_1_q       <= fp_ind_1_d;
      fp_ind_2_q       <= fp_ind_2_d;
      retire_pd_1_q    <= retire_pd_1_d;
      retire_pd_2_q    <= retire_pd_2_d;
      retire_data_1_q  <= retire_data_1_d;
      retire_data_2_q  <= retire_data_2_d;
      retire_store_1_q <= retire_store_1_d;
      retire_store_2_q <= retire_store_2_d;
    end
  end

  assign retire_valid_1 = retire_valid_1_q;
  assign retire_valid_2 = retire_valid_2_q;
  assign retire_flag_1  = retire_flag_1_q;
  assign retire_flag_2  = retire_flag_2_q;
  assign fp_ind_1       = fp_ind_1_q;
  assign fp_ind_2       = fp_ind_2_q;
  assign retire_pd_1    = retire_pd_1_q;
  assign retire_pd_2    = retire_pd_2_q;
  assign retire_data_1  = retire_data_1_q;
  assign retire_data_2  = retire_data_2_q;
  assign retire_store_1 = retire_store_1_q;
  assign retire_store_2 = retire_store_2_q;
  assign rob_count      = count_q;

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: hand-computed expectations checked with immediate assertions.
module tb_rob_retire;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid_1, alloc_valid_2;
  logic [5:0]  alloc_pd_1, alloc_pd_2, alloc_old_pd_1, alloc_old_pd_2;
  logic        alloc_store_1, alloc_store_2;
  logic        alloc_ready;
  logic [3:0]  alloc_idx_1, alloc_idx_2;
  logic        cmp_valid_1, cmp_valid_2, cmp_valid_3;
  logic [3:0]  cmp_rob_1, cmp_rob_2, cmp_rob_3;
  logic [31:0] cmp_result_1, cmp_result_2, cmp_result_3;
  logic        retire_valid_1, retire_valid_2, retire_flag_1, retire_flag_2;
  logic [5:0]  fp_ind_1, fp_ind_2, retire_pd_1, retire_pd_2;
  logic [31:0] retire_data_1, retire_data_2;
  logic        retire_store_1, retire_store_2;
  logic [4:0]  rob_count;

  int tests = 0;
  int fails = 0;

  rob_retire dut (
    .clk(clk), .rst(rst),
    .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
    .alloc_pd_1(alloc_pd_1), .alloc_pd_2(alloc_pd_2),
    .alloc_old_pd_1(alloc_old_pd_1), .alloc_old_pd_2(alloc_old_pd_2),
    .alloc_store_1(alloc_store_1), .alloc_store_2(alloc_store_2),
    .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
    .cmp_valid_1(cmp_valid_1), .cmp_valid_2(cmp_valid_2), .cmp_valid_3(cmp_valid_3),
    .cmp_rob_1(cmp_rob_1), .cmp_rob_2(cmp_rob_2), .cmp_rob_3(cmp_rob_3),
    .cmp_result_1(cmp_result_1), .cmp_result_2(cmp_result_2), .cmp_result_3(cmp_result_3),
    .retire_valid_1(retire_valid_1), .retire_valid_2(retire_valid_2),
    .retire_flag_1(retire_flag_1), .retire_flag_2(retire_flag_2),
    .fp_ind_1(fp_ind_1), .fp_ind_2(fp_ind_2),
    .retire_pd_1(retire_pd_1), .retire_pd_2(retire_pd_2),
    .retire_data_1(retire_data_1), .retire_data_2(retire_data_2),
    .retire_store_1(retire_store_1), .retire_store_2(retire_store_2),
    .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    alloc_valid_1 = 1'b0; alloc_valid_2 = 1'b0;
    alloc_pd_1 = 6'd0; alloc_pd_2 = 6'd0; alloc_old_pd_1 = 6'd0; alloc_old_pd_2 = 6'd0;
    alloc_store_1 = 1'b0; alloc_store_2 = 1'b0;
    cmp_valid_1 = 1'b0; cmp_valid_2 = 1'b0; cmp_valid_3 = 1'b0;
    cmp_rob_1 = 4'd0; cmp_rob_2 = 4'd0; cmp_rob_3 = 4'd0;
    cmp_result_1 = 32'd0; cmp_result_2 = 32'd0; cmp_result_3 = 32'd0;
  endtask

  task automatic alloc2(input logic [5:0] pd1, input logic [5:0] pd2,
                        input logic [5:0] old1, input logic [5:0] old2);
    alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
    alloc_pd_1 = pd1; alloc_pd_2 = pd2; alloc_old_pd_1 = old1; alloc_old_pd_2 = old2;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    tick();
    tick();
    rst = 1'b0;
    check("reset_count", {27'd0, rob_count}, 32'd0);
    check("reset_rv1", {31'd0, retire_valid_1}, 32'd0);
    check("reset_rv2", {31'd0, retire_valid_2}, 32'd0);
    check("reset_ready", {31'd0, alloc_ready}, 32'd1);
    check("reset_idx1", {28'd0, alloc_idx_1}, 32'd0);

    // Dual alloc, out-of-order completion, paired retire
    alloc2(6'd33, 6'd34, 6'd5, 6'd6);
    #1;
    check("pair_idx1", {28'd0, alloc_idx_1}, 32'd0);
    check("pair_idx2", {28'd0, alloc_idx_2}, 32'd1);
    tick(); clear_in();
    check("pair_count", {27'd0, rob_count}, 32'd2);
    cmp_valid_1 = 1'b1; cmp_rob_1 = 4'd1; cmp_result_1 = 32'h11;
    tick(); clear_in();
    check("pair_noret_a", {31'd0, retire_valid_1}, 32'd0);
    cmp_valid_1 = 1'b1; cmp_rob_1 = 4'd0; cmp_result_1 = 32'h22;
    tick(); clear_in();
    check("pair_noret_b", {31'd0, retire_valid_1}, 32'd0);
    tick();
    check("pair_rv1", {31'd0, retire_valid_1}, 32'd1);
    check("pair_rv2", {31'd0, retire_valid_2}, 32'd1);
    check("pair_fp1", {26'd0, fp_ind_1}, 32'd5);
    check("pair_fp2", {26'd0, fp_ind_2}, 32'd6);
    check("pair_pd1", {26'd0, retire_pd_1}, 32'd33);
    check("pair_pd2", {26'd0, retire_pd_2}, 32'd34);
    check("pair_data1", retire_data_1, 32'h22);
    check("pair_data2", retire_data_2, 32'h11);
    check("pair_flag1", {31'd0, retire_flag_1}, 32'd1);
    check("pair_count0", {27'd0, rob_count}, 32'd0);
    tick();
    check("pair_pulse_end", {31'd0, retire_valid_1}, 32'd0);
    check("pair_fp1_clr", {26'd0, fp_ind_1}, 32'd0);

    // Fill from tail=2: 8 dual allocs, then overflow attempt
    for (int i = 0; i < 8; i++) begin
      alloc2(6'(i), 6'(i + 8), 6'd1, 6'd2);
      tick();
    end
    clear_in();
    check("fill_count", {27'd0, rob_count}, 32'd16);
    check("fill_ready", {31'd0, alloc_ready}, 32'd0);
    check("fill_idx1", {28'd0, alloc_idx_1}, 32'd2);
    alloc2(6'd60, 6'd61, 6'd3, 6'd4);
    tick(); clear_in();
    check("ovf_count", {27'd0, rob_count}, 32'd16);
    check("ovf_idx1", {28'd0, alloc_idx_1}, 32'd2);
    do_reset();
    check("full_rst_count", {27'd0, rob_count}, 32'd0);

    // Wrap: 15 rows, drain, then allocate across the wrap point
    for (int i = 0; i < 7; i++) begin
      alloc2(6'd1, 6'd2, 6'd3, 6'd4);
      tick();
    end
    clear_in();
    alloc_valid_1 = 1'b1;
    tick(); clear_in();
    check("wrap_count15", {27'd0, rob_count}, 32'd15);
    check("wrap_ready15", {31'd0, alloc_ready}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      cmp_valid_1 = 1'b1; cmp_rob_1 = 4'(3 * c);
      cmp_valid_2 = 1'b1; cmp_rob_2 = 4'(3 * c + 1);
      cmp_valid_3 = 1'b1; cmp_rob_3 = 4'(3 * c + 2);
      tick();
    end
    clear_in();
    for (int i = 0; i < 12; i++) tick();
    check("wrap_drained", {27'd0, rob_count}, 32'd0);
    alloc2(6'd50, 6'd51, 6'd20, 6'd21);
    #1;
    check("wrap_idx1", {28'd0, alloc_idx_1}, 32'd15);
    check("wrap_idx2", {28'd0, alloc_idx_2}, 32'd0);
    tick(); clear_in();
    cmp_valid_1 = 1'b1; cmp_rob_1 = 4'd0; cmp_result_1 = 32'h100;
    tick(); clear_in();
    cmp_valid_2 = 1'b1; cmp_rob_2 = 4'd15; cmp_result_2 = 32'h200;
    tick(); clear_in();
    check("wrap_noret", {31'd0, retire_valid_1}, 32'd0);
    tick();
    check("wrap_rv1", {31'd0, retire_valid_1}, 32'd1);
    check("wrap_pd1", {26'd0, retire_pd_1}, 32'd50);
    check("wrap_rv2", {31'd0, retire_valid_2}, 32'd1);
    check("wrap_pd2", {26'd0, retire_pd_2}, 32'd51);
    check("wrap_data1", retire_data_1, 32'h200);
    check("wrap_fp1", {26'd0, fp_ind_1}, 32'd20);

    // Store retires without a free-pool release (head=tail=1)
    alloc_valid_1 = 1'b1; alloc_store_1 = 1'b1; alloc_pd_1 = 6'd40; alloc_old_pd_1 = 6'd7;
    #1;
    check("store_idx1", {28'd0, alloc_idx_1}, 32'd1);
    tick(); clear_in();
    cmp_valid_2 = 1'b1; cmp_rob_2 = 4'd1; cmp_result_2 = 32'h1234;
    tick(); clear_in();
    tick();
    check("store_rv1", {31'd0, retire_valid_1}, 32'd1);
    check("store_st1", {31'd0, retire_store_1}, 32'd1);
    check("store_flag1", {31'd0, retire_flag_1}, 32'd0);
    check("store_fp1", {26'd0, fp_ind_1}, 32'd0);
    check("store_pd1", {26'd0, retire_pd_1}, 32'd40);
    check("store_data1", retire_data_1, 32'h1234);
    check("store_rv2", {31'd0, retire_valid_2}, 32'd0);

    // Way 2 alone writes at tail (tail=2)
    alloc_valid_2 = 1'b1; alloc_pd_2 = 6'd12; alloc_old_pd_2 = 6'd9;
    #1;
    check("w2_idx2", {28'd0, alloc_idx_2}, 32'd2);
    tick(); clear_in();
    check("w2_count", {27'd0, rob_count}, 32'd1);
    cmp_valid_3 = 1'b1; cmp_rob_3 = 4'd2; cmp_result_3 = 32'h77;
    tick(); clear_in();
    tick();
    check("w2_rv1", {31'd0, retire_valid_1}, 32'd1);
    check("w2_pd1", {26'd0, retire_pd_1}, 32'd12);
    check("w2_fp1", {26'd0, fp_ind_1}, 32'd9);
    check("w2_rv2", {31'd0, retire_valid_2}, 32'd0);

    // Completion-port priority on row 4
    do_reset();
    alloc2(6'd1, 6'd2, 6'd3, 6'd4); tick();
    alloc2(6'd1, 6'd2, 6'd3, 6'd4); tick();
    clear_in();
    alloc_valid_1 = 1'b1; tick(); clear_in();
    check("prio_count", {27'd0, rob_count}, 32'd5);
    cmp_valid_1 = 1'b1; cmp_rob_1 = 4'd0;
    cmp_valid_2 = 1'b1; cmp_rob_2 = 4'd1;
    cmp_valid_3 = 1'b1; cmp_rob_3 = 4'd2;
    tick(); clear_in();
    cmp_valid_1 = 1'b1; cmp_rob_1 = 4'd3;
    tick(); clear_in();
    check("prio_ret01", {30'd0, retire_valid_2, retire_valid_1}, 32'd3);
    cmp_valid_1 = 1'b1; cmp_rob_1 = 4'd4; cmp_result_1 = 32'hAAAA;
    cmp_valid_3 = 1'b1; cmp_rob_3 = 4'd4; cmp_result_3 = 32'hBBBB;
    tick(); clear_in();
    check("prio_ret23", {30'd0, retire_valid_2, retire_valid_1}, 32'd3);
    tick();
    check("prio_rv1", {31'd0, retire_valid_1}, 32'd1);
    check("prio_data1", retire_data_1, 32'hAAAA);
    check("prio_rv2", {31'd0, retire_valid_2}, 32'd0);
    check("prio_count0", {27'd0, rob_count}, 32'd0);

    // Reset with live rows 5..10, rows 7..9 completed; inputs during reset discarded
    for (int i = 0; i < 3; i++) begin
      alloc2(6'd1, 6'd2, 6'd3, 6'd4);
      tick();
    end
    clear_in();
    cmp_valid_1 = 1'b1; cmp_rob_1 = 4'd7;
    cmp_valid_2 = 1'b1; cmp_rob_2 = 4'd8;
    cmp_valid_3 = 1'b1; cmp_rob_3 = 4'd9;
    tick(); clear_in();
    check("live_count", {27'd0, rob_count}, 32'd6);
    check("live_noret", {31'd0, retire_valid_1}, 32'd0);
    rst = 1'b1;
    alloc_valid_1 = 1'b1;
    cmp_valid_1 = 1'b1; cmp_rob_1 = 4'd5;
    tick();
    rst = 1'b0; clear_in();
    check("mrst_count", {27'd0, rob_count}, 32'd0);
    check("mrst_rv1", {31'd0, retire_valid_1}, 32'd0);
    check("mrst_idx1", {28'd0, alloc_idx_1}, 32'd0);
    tick();
    check("mrst_quiet_count", {27'd0, rob_count}, 32'd0);
    check("mrst_quiet_rv1", {31'd0, retire_valid_1}, 32'd0);
    alloc_valid_1 = 1'b1;
    #1;
    check("post_rst_idx1", {28'd0, alloc_idx_1}, 32'd0);
    tick(); clear_in();
    check("post_rst_count", {27'd0, rob_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rob_retire.md
ROB_RETIRE -- requirements
Module: rob_retire

Interface
REQ-001 Parameter: ROB_DEPTH, 16, number of ROB rows; fixed power of two, index width 4.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 alloc_valid_1 / alloc_valid_2  input  1  allocation request, way 1 / way 2.
REQ-005 alloc_pd_k  input  6  destination physical reg (or memory tag for stores), k=1,2.
REQ-006 alloc_old_pd_k  input  6  previous physical mapping of the destination, k=1,2.
REQ-007 alloc_store_k  input  1  instruction type: 0 = register write, 1 = store to memory, k=1,2.
REQ-008 alloc_ready  output  1  at least two free rows (combinational from registered count).
REQ-009 alloc_idx_1 / alloc_idx_2  output  4  ROB row granted to way 1 / way 2 (combinational).
REQ-010 cmp_valid_j  input  1  completion from functional-unit port j, j=1,2,3.
REQ-011 cmp_rob_j  input  4  ROB row completed by port j.
REQ-012 cmp_result_j  input  32  result data for port j.
REQ-013 retire_valid_k  output  1  head-order instruction retired this cycle, k=1,2.
REQ-014 retire_flag_k  output  1  free-pool release request: retire_valid_k AND NOT store.
REQ-015 fp_ind_k  output  6  old physical reg returned to free pool; 0 when retire_flag_k=0.
REQ-016 retire_pd_k  output  6  retired destination phy reg / memory tag.
REQ-017 retire_data_k  output  32  retired result.
REQ-018 retire_store_k  output  1  retired row was a store.
REQ-019 rob_count  output  5  registered occupancy, 0..16.

Function
REQ-020 Row state: v, store, pd, old_pd, result[31:0], comp; head and tail pointers 4-bit, wrap modulo 16.
REQ-021 alloc_ready SHALL be 1 iff rob_count <= 14.
REQ-022 alloc_idx_1 = tail; alloc_idx_2 = tail+1 when alloc_valid_1=1, else tail.
REQ-023 alloc_valid_2 without alloc_valid_1: way 2 SHALL be written at tail (single allocation).
REQ-024 Allocation when alloc_ready=0 SHALL be ignored entirely (no row, pointer or count change).
REQ-025 Allocated row: v=1, comp=0, result=0; tail advances by number of accepted ways (0,1,2).
REQ-026 Completion: on cmp_valid_j with row v=1, set comp=1, result=cmp_result_j at next edge; row v=0 -> ignored.
REQ-027 Two ports naming same row in one cycle: lowest-numbered port wins.
REQ-028 Completion and allocation of same row in one cycle: allocation wins (comp=0).
REQ-029 Retire evaluated each edge on registered state: way 1 retires head if v=1 and comp=1; way 2 retires head+1 only if way 1 retires and head+1 v=1, comp=1.
REQ-030 Retired rows cleared (v=0); head advances by retire count; retire outputs registered, valid for exactly one cycle.
REQ-031 Latency: completion sampled at edge E -> earliest retire_valid high after edge E+1.
REQ-032 rob_count(next) = rob_count + accepted allocs - retires; simultaneous alloc and retire SHALL both take effect.
REQ-033 retire_valid_2=1 SHALL never occur with retire_valid_1=0; retirement strictly in allocation order.
REQ-034 Non-retiring cycle: all retire_* outputs 0.

Reset
REQ-035 rst=1 at an edge: head=tail=0, rob_count=0, all v=0, comp=0, all retire_* outputs 0, regardless of in-flight state.
REQ-036 Allocations and completions presented during the rst cycle SHALL be discarded.
REQ-037 First allocation after reset SHALL receive alloc_idx_1=0.

Verification
REQ-038 Reset, alloc 2 (pd 33/34, old 5/6), complete row 1 then row 0 next cycle -> no retire until both done; then retire_valid_1/2=1, fp_ind_1=5, fp_ind_2=6 same cycle.
REQ-039 Fill: 8 cycles of dual alloc -> rob_count 16, alloc_ready=0; further alloc ignored, tail unchanged.
REQ-040 Wrap: alloc 15 rows, retire all, alloc 2 -> alloc_idx_1=15, alloc_idx_2=0; retire order 15 then 0.
REQ-041 Store row (alloc_store=1, pd 40) completes -> retire_valid_1=1, retire_store_1=1, retire_flag_1=0, fp_ind_1=0.
REQ-042 Ports 1 and 3 complete row 4 with 0xAAAA / 0xBBBB same cycle -> retire_data=0xAAAA.
REQ-043 rst asserted with 6 rows live, 3 completed -> next cycle rob_count=0, no retire pulse; subsequent alloc_idx_1=0.
